// File: rtl/irqc_pkg.sv
// Shared types and helpers for the irq_prio_ctrl priority interrupt controller.
package irqc_pkg;

  localparam int IRQC_STATE_W = 2;

  typedef enum logic [IRQC_STATE_W-1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } irqc_state_e;

  // Index width for a field addressing n items; a single item still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irqc_prio_enc.sv
// Combinational first-one finder over NBUS buses of NCH channels.
// Lowest bus wins; within a bus, lowest channel wins.
module irqc_prio_enc
  import irqc_pkg::*;
#(
  parameter  int NCH  = 9,
  parameter  int NBUS = 3,
  localparam int CW   = idx_width(NCH),
  localparam int BW   = idx_width(NBUS)
) (
  input  logic [NBUS*NCH-1:0] vec_i,
  output logic                found_o,
  output logic [BW-1:0]       bus_o,
  output logic [CW-1:0]       chan_o
);

  // Walk from the highest index down so the last hit written is the winner.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    found_o = 1'b0;
    bus_o   = '0;
    chan_o  = '0;
    for (int b = NBUS - 1; b >= 0; b--) begin
      for (int c = NCH - 1; c >= 0; c--) begin
        if (vec_i[b*NCH+c]) begin
          found_o = 1'b1;
          bus_o   = BW'(b);
          chan_o  = CW'(c);
        end
      end
    end
  end

endmodule

// File: rtl/irq_prio_ctrl.sv
// Registered priority interrupt controller with valid/ack handshake.
// Optional: define IRQC_EDGE_DETECT_EN for sticky rising-edge capture (default: level mode).
module irq_prio_ctrl
  import irqc_pkg::*;
#(
  parameter  int NCH  = 9,
  parameter  int NBUS = 3,
  localparam int CW   = idx_width(NCH),
  localparam int BW   = idx_width(NBUS),
  localparam int NREQ = NBUS * NCH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NCH-1:0]  chan_en,
  output logic            irq_valid,
  output logic [BW-1:0]   irq_bus,
  output logic [CW-1:0]   irq_chan,
  input  logic            irq_ack,
  output logic [NBUS-1:0] bus_any
);

  irqc_state_e     state_q, state_d;
  logic [NREQ-1:0] pending_q, pending_d;
  logic [NREQ-1:0] eligible;
  logic [BW-1:0]   bus_q, bus_d;
  logic [CW-1:0]   chan_q, chan_d;
  logic [NBUS-1:0] bus_any_q, bus_any_d;
  logic            win_found;
  logic [BW-1:0]   win_bus;
  logic [CW-1:0]   win_chan;

  assign eligible = pending_q & {NBUS{chan_en}};

  irqc_prio_enc #(
    .NCH  (NCH),
    .NBUS (NBUS)
  ) u_enc (
    .vec_i   (eligible),
    .found_o (win_found),
    .bus_o   (win_bus),
    .chan_o  (win_chan)
  );

`ifdef IRQC_EDGE_DETECT_EN
  logic [NREQ-1:0] req_q;
  logic [NREQ-1:0] clr_mask;
  logic            ack_fire;

  assign ack_fire = (state_q == PRESENT) && irq_ack;

  always_comb begin
    clr_mask = '0;
    for (int b = 0; b < NBUS; b++) begin
      for (int c = 0; c < NCH; c++) begin
        clr_mask[b*NCH+c] = ack_fire && (bus_q == BW'(b)) && (chan_q == CW'(c));
      end
    end
  end

  // A fresh edge on the bit being acked survives the clear.
  assign pending_d = (pending_q & ~clr_mask) | (req & ~req_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_q <= '0;
    else        req_q <= req;
  end
`else
  assign pending_d = req;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = PRESENT;
      PRESENT: if (irq_ack)   state_d = GAP;
      GAP:                    state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Winner is latched only when leaving IDLE, so it cannot change while presented.
  always_comb begin
    bus_d  = bus_q;
    chan_d = chan_q;
    if (state_q == IDLE && win_found) begin
      bus_d  = win_bus;
      chan_d = win_chan;
    end
    for (int b = 0; b < NBUS; b++) begin
      bus_any_d[b] = |eligible[b*NCH +: NCH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      bus_q     <= '0;
      chan_q    <= '0;
      bus_any_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      pending_q <= pending_d;
      bus_q     <= bus_d;
      chan_q    <= chan_d;
      bus_any_q <= bus_any_d;
    end
  end

  assign irq_valid = (state_q == PRESENT);
  assign irq_bus   = bus_q;
  assign irq_chan  = chan_q;
  assign bus_any   = bus_any_q;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Self-checking bench for irq_prio_ctrl (NCH=9, NBUS=3); adapts to IRQC_EDGE_DETECT_EN.
module tb_irq_prio_ctrl;

  localparam int NCH  = 9;
  localparam int NBUS = 3;
  localparam int CW   = 4;
  localparam int BW   = 2;

  typedef struct {
    int bus;
    int chan;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NBUS*NCH-1:0] req = '0;
  logic [NCH-1:0]      chan_en = '1;
  logic                irq_ack = 1'b0;
  logic                irq_valid;
  logic [BW-1:0]       irq_bus;
  logic [CW-1:0]       irq_chan;
  logic [NBUS-1:0]     bus_any;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  irq_prio_ctrl #(
    .NCH  (NCH),
    .NBUS (NBUS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .chan_en   (chan_en),
    .irq_valid (irq_valid),
    .irq_bus   (irq_bus),
    .irq_chan  (irq_chan),
    .irq_ack   (irq_ack),
    .bus_any   (bus_any)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled at the falling edge.
  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (irq_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic ack_drop(input int b, input int c);
    irq_ack = 1'b1;
    req[b*NCH+c] = 1'b0;
    @(negedge clk);
    irq_ack = 1'b0;
  endtask

  task automatic do_reset;
    req = '0;
    irq_ack = 1'b0;
    chan_en = '1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    exp_t e;
    rst_n = 1'b0;
    req = '1;
    chan_en = '1;
    repeat (3) @(negedge clk);
    checks++;
    if ({irq_valid, irq_bus, irq_chan, bus_any} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b bus=%0d ch=%0d any=%b want all zero",
               irq_valid, irq_bus, irq_chan, bus_any);
    end
    rst_n = 1'b1;
    sb.push_back('{bus: 0, chan: 0});
    @(negedge clk);
    checks++;
    if (irq_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_cycle1: irq_valid=%b want 0", irq_valid);
    end
    @(negedge clk);
    checks++;
    if (irq_valid !== 1'b1 || bus_any !== 3'b111) begin
      failures++;
      $display("FAIL reset_cycle2: irq_valid=%b bus_any=%b want 1 / 111", irq_valid, bus_any);
    end
    e = sb.pop_front();
    checks++;
    if (irq_bus !== BW'(e.bus) || irq_chan !== CW'(e.chan)) begin
      failures++;
      $display("FAIL reset_winner: got (%0d,%0d) want (%0d,%0d)", irq_bus, irq_chan, e.bus, e.chan);
    end
    do_reset();
  endtask

  task automatic test_priority;
    exp_t e;
    bit   ok;
    req[1*NCH+2] = 1'b1;
    req[0*NCH+7] = 1'b1;
    sb.push_back('{bus: 0, chan: 7});
    sb.push_back('{bus: 1, chan: 2});
    @(negedge clk);
    wait_valid(10, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL prio_first_timeout: irq_valid=0 want 1");
    end
    e = sb.pop_front();
    checks++;
    if (irq_bus !== BW'(e.bus) || irq_chan !== CW'(e.chan)) begin
      failures++;
      $display("FAIL prio_first: got (%0d,%0d) want (%0d,%0d)", irq_bus, irq_chan, e.bus, e.chan);
    end
    ack_drop(0, 7);
    checks++;
    if (irq_valid !== 1'b0) begin
      failures++;
      $display("FAIL prio_gap: irq_valid=%b want 0", irq_valid);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (irq_valid !== 1'b1) begin
      failures++;
      $display("FAIL prio_ack_to_next: irq_valid=%b want 1 three cycles after ack", irq_valid);
    end
    e = sb.pop_front();
    checks++;
    if (irq_bus !== BW'(e.bus) || irq_chan !== CW'(e.chan)) begin
      failures++;
      $display("FAIL prio_second: got (%0d,%0d) want (%0d,%0d)", irq_bus, irq_chan, e.bus, e.chan);
    end
    ack_drop(1, 2);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (irq_valid !== 1'b0) begin
        failures++;
        $display("FAIL prio_drained: irq_valid=%b want 0 at cycle %0d", irq_valid, i);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_enable_mask;
    exp_t e;
    chan_en = '1;
    chan_en[4] = 1'b0;
    req[2*NCH+4] = 1'b1;
    @(negedge clk);
`ifdef IRQC_EDGE_DETECT_EN
    req[2*NCH+4] = 1'b0;
`endif
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (irq_valid !== 1'b0 || bus_any !== 3'b000) begin
        failures++;
        $display("FAIL enable_masked: irq_valid=%b bus_any=%b want 0 / 000 at cycle %0d",
                 irq_valid, bus_any, i);
      end
    end
    chan_en[4] = 1'b1;
    sb.push_back('{bus: 2, chan: 4});
    @(negedge clk);
    checks++;
    if (irq_valid !== 1'b1 || bus_any !== 3'b100) begin
      failures++;
      $display("FAIL enable_resume: irq_valid=%b bus_any=%b want 1 / 100", irq_valid, bus_any);
    end
    e = sb.pop_front();
    checks++;
    if (irq_bus !== BW'(e.bus) || irq_chan !== CW'(e.chan)) begin
      failures++;
      $display("FAIL enable_winner: got (%0d,%0d) want (%0d,%0d)", irq_bus, irq_chan, e.bus, e.chan);
    end
    ack_drop(2, 4);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_hold;
    exp_t e;
    bit   ok;
    req[2*NCH+0] = 1'b1;
    sb.push_back('{bus: 2, chan: 0});
    @(negedge clk);
    wait_valid(10, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL hold_first_timeout: irq_valid=0 want 1");
    end
    e = sb.pop_front();
    checks++;
    if (irq_bus !== BW'(e.bus) || irq_chan !== CW'(e.chan)) begin
      failures++;
      $display("FAIL hold_first: got (%0d,%0d) want (%0d,%0d)", irq_bus, irq_chan, e.bus, e.chan);
    end
    req[0*NCH+0] = 1'b1;
    sb.push_back('{bus: 0, chan: 0});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (irq_valid !== 1'b1 || irq_bus !== 2'd2 || irq_chan !== 4'd0) begin
        failures++;
        $display("FAIL hold_stable: got v=%b (%0d,%0d) want 1 (2,0) at cycle %0d",
                 irq_valid, irq_bus, irq_chan, i);
      end
    end
    ack_drop(2, 0);
    wait_valid(10, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL hold_next_timeout: irq_valid=0 want 1");
    end
    e = sb.pop_front();
    checks++;
    if (irq_bus !== BW'(e.bus) || irq_chan !== CW'(e.chan)) begin
      failures++;
      $display("FAIL hold_next: got (%0d,%0d) want (%0d,%0d)", irq_bus, irq_chan, e.bus, e.chan);
    end
    ack_drop(0, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_collision;
    exp_t e;
    bit   ok;
    req[1*NCH+1] = 1'b1;
    sb.push_back('{bus: 1, chan: 1});
    @(negedge clk);
    req[1*NCH+1] = 1'b0;
    wait_valid(10, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL collide_first_timeout: irq_valid=0 want 1");
    end
    e = sb.pop_front();
    checks++;
    if (irq_bus !== BW'(e.bus) || irq_chan !== CW'(e.chan)) begin
      failures++;
      $display("FAIL collide_first: got (%0d,%0d) want (%0d,%0d)", irq_bus, irq_chan, e.bus, e.chan);
    end
    irq_ack = 1'b1;
    req[1*NCH+1] = 1'b1;
    sb.push_back('{bus: 1, chan: 1});
    @(negedge clk);
    irq_ack = 1'b0;
    checks++;
    if (irq_valid !== 1'b0) begin
      failures++;
      $display("FAIL collide_gap: irq_valid=%b want 0", irq_valid);
    end
    wait_valid(10, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL collide_again_timeout: irq_valid=0 want 1");
    end
    e = sb.pop_front();
    checks++;
    if (irq_bus !== BW'(e.bus) || irq_chan !== CW'(e.chan)) begin
      failures++;
      $display("FAIL collide_again: got (%0d,%0d) want (%0d,%0d)", irq_bus, irq_chan, e.bus, e.chan);
    end
    ack_drop(1, 1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (irq_valid !== 1'b0) begin
        failures++;
        $display("FAIL collide_drained: irq_valid=%b want 0 at cycle %0d", irq_valid, i);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    bit   ok;
    req[0*NCH+1] = 1'b1;
    sb.push_back('{bus: 0, chan: 1});
    @(negedge clk);
    wait_valid(10, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rstmid_timeout: irq_valid=0 want 1");
    end
    e = sb.pop_front();
    checks++;
    if (irq_bus !== BW'(e.bus) || irq_chan !== CW'(e.chan)) begin
      failures++;
      $display("FAIL rstmid_winner: got (%0d,%0d) want (%0d,%0d)", irq_bus, irq_chan, e.bus, e.chan);
    end
    #1;
    rst_n = 1'b0;
    req = '0;
    #1;
    checks++;
    if ({irq_valid, irq_bus, irq_chan, bus_any} !== '0) begin
      failures++;
      $display("FAIL rstmid_async: got v=%b bus=%0d ch=%0d any=%b want all zero",
               irq_valid, irq_bus, irq_chan, bus_any);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (irq_valid !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_quiet: irq_valid=%b want 0 at cycle %0d", irq_valid, i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_enable_mask();
    test_hold();
    test_collision();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_empty: %0d entries left want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
